// File: rtl/uart_rx_dispatch_if.sv
// Byte-stream and consumer-channel bundle for uart_rx_dispatch.
// master: the dispatcher (takes the receiver byte stream, drives the channels).
// slave : the surroundings (UART receiver plus the consumer channels).
//   rx_done_tick/rx_data : one received byte, valid for one cycle
//   ch_valid (one-hot)   : byte offered to channel i
//   ch_data/ch_last      : offered byte, shared by all channels; last flag
//   ch_ready             : per-channel accept
interface uart_rx_dispatch_if #(
  parameter int NCH = 4
);
  logic           rx_done_tick;
  logic [7:0]     rx_data;
  logic [NCH-1:0] ch_valid;
  logic [7:0]     ch_data;
  logic           ch_last;
  logic [NCH-1:0] ch_ready;

  modport master (
    input  rx_done_tick, rx_data, ch_ready,
    output ch_valid, ch_data, ch_last
  );

  modport slave (
    output rx_done_tick, rx_data, ch_ready,
    input  ch_valid, ch_data, ch_last
  );
endinterface

// File: rtl/uart_rx_dispatch.sv
// Buffers UART receive bytes in a show-ahead FIFO, parses SYNC/HDR/LEN/payload
// frames and steers each payload to one of NCH consumers over valid/ready.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   bus (master) : byte stream in, consumer channels out
//   clr_err      : synchronous clear of the sticky flags (a same-cycle set wins)
//   overrun      : sticky, a byte was dropped because the FIFO was full
//   frame_err    : sticky, a frame named a destination >= NCH
//   busy         : parser is mid-frame or the FIFO holds data
//
// state | meaning
// HUNT  | discard bytes until SYNC
// HDR   | latch destination from the header byte
// LEN   | latch payload length; route to PAY, DROP, or back to HUNT
// PAY   | offer payload bytes to the selected channel
// DROP  | silently consume the payload of a frame with a bad destination
module uart_rx_dispatch #(
  parameter int         NCH   = 4,
  parameter int         DEPTH = 16,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  uart_rx_dispatch_if.master bus,
  input  logic              clr_err,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {HUNT, HDR, LEN, PAY, DROP} state_t;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           full, empty, push, pop;
  logic [7:0]     head;

  state_t         state, state_nxt;
  logic [3:0]     dest, dest_nxt;
  logic           bad, bad_nxt;
  logic [7:0]     len, len_nxt;
  logic           ferr_set, ovr_set;
  logic [NCH-1:0] ch_valid_c;
  logic           ch_last_c;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A write into a full FIFO still fits when the FSM pops in the same cycle.
  assign push    = bus.rx_done_tick && (!full || pop);
  assign ovr_set = bus.rx_done_tick && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
      dest  <= '0;
      bad   <= 1'b0;
      len   <= '0;
    end else begin
      state <= state_nxt;
      dest  <= dest_nxt;
      bad   <= bad_nxt;
      len   <= len_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    dest_nxt   = dest;
    bad_nxt    = bad;
    len_nxt    = len;
    pop        = 1'b0;
    ferr_set   = 1'b0;
    ch_valid_c = '0;
    ch_last_c  = 1'b0;
    case (state)
      HUNT: begin
        if (!empty) begin
          pop = 1'b1;
          if (head == SYNC) state_nxt = HDR;
        end
      end
      HDR: begin
        if (!empty) begin
          pop       = 1'b1;
          dest_nxt  = head[3:0];
          bad_nxt   = ({1'b0, head[3:0]} >= 5'(NCH));
          state_nxt = LEN;
        end
      end
      LEN: begin
        if (!empty) begin
          pop     = 1'b1;
          len_nxt = head;
          if (head == 8'd0) begin
            state_nxt = HUNT;
            ferr_set  = bad;
          end else if (bad) begin
            state_nxt = DROP;
            ferr_set  = 1'b1;
          end else begin
            state_nxt = PAY;
          end
        end
      end
      PAY: begin
        ch_last_c = (len == 8'd1);
        for (int i = 0; i < NCH; i++) begin
          if (dest == 4'(i)) begin
            ch_valid_c[i] = !empty;
            if (!empty && bus.ch_ready[i]) pop = 1'b1;
          end
        end
        if (pop) begin
          len_nxt = len - 1'b1;
          if (len == 8'd1) state_nxt = HUNT;
        end
      end
      DROP: begin
        if (!empty) begin
          pop     = 1'b1;
          len_nxt = len - 1'b1;
          if (len == 8'd1) state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  assign bus.ch_valid = ch_valid_c;
  assign bus.ch_last  = ch_last_c;
  assign bus.ch_data  = head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set  | (overrun   & ~clr_err);
      frame_err <= ferr_set | (frame_err & ~clr_err);
    end
  end

  assign busy = (state != HUNT) || !empty;

endmodule
